// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SEND   = 2'd2,
        WAIT   = 2'd3
    } arb_state_t;

    localparam int DBIT_DEFAULT = 8;

    // Width of an index able to name any of n requesters (at least one bit).
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority-rotate round-robin picker
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant_idx,
    output logic         found
);

    localparam logic [W:0] NW = (W+1)'(N);

    logic [W-1:0]   start;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   sel;
    logic [W:0]     sum;

    // Rotate so the index after last_grant sits at bit 0, take the lowest set
    // bit, then rotate the winning position back into absolute numbering.
    always_comb begin
        start = (last_grant == W'(N-1)) ? '0 : last_grant + 1'b1;
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        sel   = '0;
        found = 1'b0;
        for (int i = N-1; i >= 0; i--) begin
            if (rot[i]) begin
                sel   = W'(i);
                found = 1'b1;
            end
        end
        sum       = {1'b0, sel} + {1'b0, start};
        grant_idx = (sum >= NW) ? W'(sum - NW) : sum[W-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin sharing of one uart_tx
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DBIT        = DBIT_DEFAULT,
    parameter int MAX_MSG_LEN = 64,
    localparam int GW         = grant_width(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*DBIT-1:0] req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    tx_start,
    output logic [DBIT-1:0]         din,
    input  logic                    tx_done_tick,
    output logic                    busy,
    output logic [GW-1:0]           grant_id
);

    arb_state_t state, state_next;

    logic [GW-1:0]   last_grant;
    logic [7:0]      byte_cnt;
    logic            last_reg;

    logic [GW-1:0]   pick_idx;
    logic            pick_found;

    logic            load_grant;
    logic            xfer;
    logic            rel_grant;

    logic            cur_valid;
    logic            cur_last;
    logic [DBIT-1:0] cur_data;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (GW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant_idx  (pick_idx),
        .found      (pick_found)
    );

    // Slice out the grantee's current byte and flags.
    always_comb begin
        cur_valid = req_valid[grant_id];
        cur_last  = req_last[grant_id];
        cur_data  = req_data[grant_id*DBIT +: DBIT];
    end

    // Arbiter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the combinational ready strobe for the grantee.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        load_grant = 1'b0;
        xfer       = 1'b0;
        rel_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    load_grant = 1'b1;
                    state_next = ACCEPT;
                end
            end
            ACCEPT: begin
                req_ready[grant_id] = cur_valid;
                if (cur_valid) begin
                    xfer       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    if (last_reg) begin
                        rel_grant  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = ACCEPT;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping, byte capture and the one-cycle start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id   <= '0;
            busy       <= 1'b0;
            last_grant <= GW'(NUM_REQ-1);
            byte_cnt   <= '0;
            last_reg   <= 1'b0;
            din        <= '0;
            tx_start   <= 1'b0;
        end else begin
            tx_start <= xfer;
            if (load_grant) begin
                grant_id <= pick_idx;
                busy     <= 1'b1;
                byte_cnt <= '0;
            end
            if (xfer) begin
                din      <= cur_data;
                // Hitting the length cap ends the message just like a last byte.
                last_reg <= cur_last | (byte_cnt == 8'(MAX_MSG_LEN-1));
                if (byte_cnt < 8'(MAX_MSG_LEN)) begin
                    byte_cnt <= byte_cnt + 8'd1;
                end
            end
            if (rel_grant) begin
                last_grant <= grant_id;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int DB  = 8;
    localparam int MML = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DB-1:0]  req_data = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR-1:0]     req_ready;
    logic              tx_start;
    logic [DB-1:0]     din;
    logic              tx_done_tick;
    logic              busy;
    logic [1:0]        grant_id;
    logic              uart_tick = 1'b0;
    logic              spur_tick = 1'b0;

    assign tx_done_tick = uart_tick | spur_tick;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .DBIT        (DB),
        .MAX_MSG_LEN (MML)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .din          (din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [8:0] src_q [NR][$];
    logic [8:0] exp_q [NR][$];
    logic [NR-1:0] pause = '0;
    int served_q[$];
    int len_q[$];
    int sent_cnt [NR];
    int tx_count = 0;
    int rst_epoch = 0;

    bit m_idle = 1'b1;
    bit m_infl = 1'b0;
    bit m_xfer = 1'b0;
    bit m_end = 1'b0;
    int m_gnt = 0;
    int m_last = NR-1;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_list(input string name, input int got[$], input int exp[$]);
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(name, got[i], exp[i]);
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input bit last);
        src_q[r].push_back({last, d});
        exp_q[r].push_back({last, d});
    endtask

    task automatic send_rand(input int r, input int len);
        for (int j = 0; j < len; j++)
            push_byte(r, 8'($urandom_range(0, 255)), (j == len-1));
    endtask

    // One clock of the requester drivers: retire accepted bytes, present the next.
    task automatic step();
        logic [NR-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && src_q[i].size() > 0)
                src_q[i].delete(0);
            if (!pause[i] && src_q[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i*DB +: DB] = src_q[i][0][7:0];
                req_last[i] = src_q[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DB +: DB] = '0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic run_until_idle(input int bound);
        int c;
        bit pend;
        bit done;
        c = 0;
        done = 0;
        while (!done && c < bound) begin
            pend = 0;
            for (int i = 0; i < NR; i++)
                if (src_q[i].size() > 0) pend = 1;
            if (!pend && m_idle && !m_infl) done = 1;
            else begin
                step();
                c++;
            end
        end
        chk("drain_in_time", 32'(done), 1);
    endtask

    task automatic wait_sent(input int r, input int target, input int bound);
        int c;
        c = 0;
        while (sent_cnt[r] < target && c < bound) begin
            step();
            c++;
        end
        chk("wait_sent", sent_cnt[r], target);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_start"}, 32'(tx_start), 0);
        chk({tag, "_din"}, 32'(din), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_grant_id"}, 32'(grant_id), 0);
    endtask

    // Reference model: message-level round robin, checked every cycle.
    initial begin
        logic [NR-1:0] exp_rdy;
        logic [8:0] e;
        bit hit;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_idle = 1; m_infl = 0; m_xfer = 0; m_end = 0;
                m_last = NR-1; m_cnt = 0;
            end else begin
                chk("busy", 32'(busy), 32'(!m_idle));
                exp_rdy = (!m_idle && !m_infl) ? (req_valid & (NR'(1) << m_gnt)) : '0;
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                chk("tx_start", 32'(tx_start), 32'(m_xfer));
                if (tx_start) begin
                    tx_count++;
                    chk("grant_id", 32'(grant_id), m_gnt);
                    if (exp_q[m_gnt].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got %0h from requester %0d, expected none", din, m_gnt);
                    end else begin
                        e = exp_q[m_gnt].pop_front();
                        chk("din", 32'(din), 32'(e[7:0]));
                        m_cnt++;
                        m_end = e[8] || (m_cnt == MML);
                        sent_cnt[m_gnt]++;
                    end
                end
                m_xfer = 0;
                if (m_idle) begin
                    hit = 0;
                    for (int k = 1; k <= NR; k++) begin
                        if (!hit && req_valid[(m_last + k) % NR]) begin
                            hit = 1;
                            m_gnt = (m_last + k) % NR;
                        end
                    end
                    if (hit) begin
                        m_idle = 0;
                        m_cnt = 0;
                        served_q.push_back(m_gnt);
                    end
                end else if (!m_infl) begin
                    if (req_valid[m_gnt]) begin
                        m_infl = 1;
                        m_xfer = 1;
                    end
                end else if (tx_done_tick) begin
                    m_infl = 0;
                    if (m_end) begin
                        m_idle = 1;
                        m_last = m_gnt;
                        len_q.push_back(m_cnt);
                    end
                end
            end
        end
    end

    // Stand-in for uart_tx: random short frame time, din must hold until done.
    initial begin
        logic [DB-1:0] cap;
        int n;
        int ep;
        bit ab;
        bit stable;
        forever begin
            @(negedge clk);
            if (!reset && tx_start) begin
                cap = din;
                ep = rst_epoch;
                n = $urandom_range(2, 10);
                ab = 0;
                stable = 1;
                repeat (n) begin
                    @(negedge clk);
                    if (rst_epoch != ep) ab = 1;
                    else if (din !== cap) stable = 0;
                end
                if (!ab) begin
                    chk("din_stable", 32'(stable), 1);
                    @(posedge clk);
                    #1 uart_tick = 1'b1;
                    @(posedge clk);
                    #1 uart_tick = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int base;
        int eq[$];
        int el[$];
        for (int i = 0; i < NR; i++) sent_cnt[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Requester 2 alone sends "AB".
        served_q.delete(); len_q.delete();
        t0 = tx_count;
        push_byte(2, 8'h41, 1'b0);
        push_byte(2, 8'h42, 1'b1);
        run_until_idle(300);
        chk("ab_pulses", tx_count - t0, 2);
        chk("ab_grant_id", 32'(grant_id), 2);
        eq = '{2}; chk_list("ab_served", served_q, eq);
        el = '{2}; chk_list("ab_len", len_q, el);

        // Spurious done tick while idle.
        t0 = tx_count;
        spur_tick = 1'b1;
        step();
        spur_tick = 1'b0;
        repeat (5) step();
        chk("spur_no_start", tx_count - t0, 0);
        chk("spur_busy", 32'(busy), 0);

        // Reset while waiting for a frame to finish.
        send_rand(2, 3);
        base = sent_cnt[2];
        wait_sent(2, base + 1, 200);
        #1;
        rst_epoch++;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        for (int i = 0; i < NR; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        req_valid = '0; req_data = '0; req_last = '0; pause = '0;
        @(negedge clk);
        #1 reset = 1'b0;
        served_q.delete();
        push_byte(3, 8'h33, 1'b1);
        push_byte(1, 8'h11, 1'b1);
        run_until_idle(300);
        eq = '{1, 3}; chk_list("post_reset_order", served_q, eq);

        // All four requesters at once, twice.
        served_q.delete();
        for (int i = 0; i < NR; i++) send_rand(i, 1);
        run_until_idle(400);
        for (int i = 0; i < NR; i++) send_rand(i, 1);
        run_until_idle(400);
        eq = '{0, 1, 2, 3, 0, 1, 2, 3}; chk_list("rr_order", served_q, eq);

        // Six-byte message is split at the length cap; requester 3 slips in.
        served_q.delete(); len_q.delete();
        send_rand(1, 6);
        base = sent_cnt[1];
        wait_sent(1, base + 1, 200);
        push_byte(3, 8'hc3, 1'b1);
        run_until_idle(600);
        eq = '{1, 3, 1}; chk_list("cap_order", served_q, eq);
        el = '{4, 1, 2}; chk_list("cap_len", len_q, el);

        // Grantee stalls for 20 cycles mid-message.
        served_q.delete(); len_q.delete();
        send_rand(0, 4);
        base = sent_cnt[0];
        wait_sent(0, base + 1, 200);
        send_rand(2, 1);
        wait_sent(0, base + 2, 200);
        pause[0] = 1'b1;
        t0 = tx_count;
        repeat (20) step();
        chk("stall_no_start", tx_count - t0, 0);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_grant_id", 32'(grant_id), 0);
        pause[0] = 1'b0;
        run_until_idle(600);
        eq = '{0, 2}; chk_list("stall_order", served_q, eq);
        el = '{4, 1}; chk_list("stall_len", len_q, el);

        // Random traffic with random valid stalls.
        repeat (600) begin
            for (int i = 0; i < NR; i++) pause[i] = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) begin
                int r;
                r = $urandom_range(0, NR-1);
                if (src_q[r].size() < 10) send_rand(r, $urandom_range(1, 7));
            end
            step();
        end
        pause = '0;
        run_until_idle(5000);
        for (int i = 0; i < NR; i++) chk("exp_drained", exp_q[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` transmitter between `NUM_REQ` independent byte-stream requesters, such as a status reporter, a text banner and a debug dump. It arbitrates round-robin at message granularity: a granted requester keeps the transmitter until it sends its `last` byte or hits `MAX_MSG_LEN` bytes. It sits between the requesters and `uart_tx`, driving `tx_start`/`din` and consuming `tx_done_tick`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DBIT`, default 8: data bits per UART frame; must match `uart_tx` `DBIT`.
- `MAX_MSG_LEN`, default 64: bytes after which the grant is forcibly released, 1..255.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a byte on its `req_data` slice.
- `req_data` in NUM_REQ*DBIT: byte of requester i at `[i*DBIT +: DBIT]`.
- `req_last` in NUM_REQ: presented byte is the last of its message.
- `req_ready` out NUM_REQ: one-hot byte-accept strobe; a byte transfers when `valid & ready`.
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `din` out DBIT: byte to `uart_tx`; stable from the `tx_start` cycle until `tx_done_tick`.
- `tx_done_tick` in 1: `uart_tx` finished the stop bit(s).
- `busy` out 1: a grant is held.
- `grant_id` out $clog2(NUM_REQ): current or most recent grantee.

## Operation
- FSM states are IDLE, ACCEPT, SEND and WAIT.
- IDLE:
  - If any `req_valid` is set, pick the first valid index scanning from `(last_grant+1) mod NUM_REQ` upward with wrap-around.
  - Register it into `grant_id`, set `busy=1`, clear `byte_cnt`, and go to ACCEPT.
- ACCEPT:
  - `req_ready[grant_id] = req_valid[grant_id]`. This is combinational; all other ready bits are 0.
  - On transfer: `din<=req_data`, `last_reg<=req_last | (byte_cnt==MAX_MSG_LEN-1)`, `byte_cnt++`, `tx_start<=1`, go to SEND.
  - If the grantee drops valid mid-message, stay in ACCEPT holding the grant. There is no timeout, and requesters must not abandon a message.
- SEND: `tx_start` is high for exactly this cycle; `tx_start<=0`, go to WAIT.
- WAIT:
  - Ignore requests.
  - On `tx_done_tick` with `last_reg=1`: `last_grant<=grant_id`, `busy<=0`, go to IDLE.
  - On `tx_done_tick` with `last_reg=0`: go to ACCEPT.
- Forced release at `MAX_MSG_LEN`:
  - Treated exactly like `last`.
  - The requester's next byte competes again in IDLE as a new message.
- `tx_done_tick` in IDLE, ACCEPT or SEND is ignored. It cannot occur legally, because `uart_tx` is idle then.
- `byte_cnt` is 8 bits and never wraps past `MAX_MSG_LEN`.
- Reset values:
  - Outputs: `tx_start=0`, `din=0`, `req_ready=0`, `busy=0`, `grant_id=0`.
  - Internal: `last_grant=NUM_REQ-1`, so requester 0 wins first; `byte_cnt=0`; state IDLE.
- Reset asserted mid-frame aborts immediately. `uart_tx` shares the same reset, so no partial handshake survives.

## Timing
- Request to first byte: `req_valid` is seen in IDLE at cycle N; `req_ready` pulses at N+1; `tx_start`/`din` are valid at N+2.
- Inter-byte, same message: `tx_done_tick` at T gives `req_ready` at T+1 (if valid) and `tx_start` at T+2.
- Message to message: `tx_done_tick` at T gives IDLE at T+1, `req_ready` at T+2, and `tx_start` at T+3.
- `req_ready` lasts at most one cycle per byte; requesters may change data the cycle after it.
- Simultaneous requests are resolved solely by the rotating priority. `last_grant` updates only on message completion.

## Structure
- Package `uart_pkg`:
  - state enum `arb_state_t` (IDLE, ACCEPT, SEND, WAIT);
  - `DBIT_DEFAULT = 8`;
  - a width helper for `grant_id`.
- Sub-module `rr_arbiter`: a combinational rotate-priority-rotate picker with inputs `req` and `last_grant` and output `grant_idx`/`found`.
- The top-level instantiates `baud_gen`, `uart_tx` and `uart_tx_arbiter` side by side.

## Test plan
Bench uses `dvsr=3` for short frames and `NUM_REQ=4`, `MAX_MSG_LEN=4`.
- After reset, only requester 2 sends "AB" with `last` on 'B' -> `din=0x41` then `0x42`, exactly two `tx_start` pulses, `grant_id=2`, `busy` falls one cycle after the second `tx_done_tick`.
- All four requesters assert valid at once, each with 1-byte messages -> service order 0,1,2,3, then 0 again if re-asserted; no requester is served twice in a row while others wait.
- Requester 1 sends a 6-byte message without `last` -> grant is released after 4 bytes; requester 3 (pending) is served next, then requester 1 resumes with byte 5.
- Grantee drops `req_valid` for 20 cycles mid-message -> grant is held, `tx_start` stays low, no other ready is asserted; transfer resumes on re-assert.
- Assert reset during WAIT -> next cycle all outputs are at reset values, and the next grant goes to the lowest valid index from 0.
- Inject a spurious `tx_done_tick` in IDLE -> no state change and no `req_ready` pulse.
